piso_tx8: RTL

//   8-bit parallel-in/serial-out transmitter; the send side of the 8-bit shift

---
 rtl/piso_tx8.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/piso_tx8.sv
// piso_tx8 - 8-bit parallel-in / serial-out transmitter.
//
// Accepts one byte per load_valid/load_ready handshake and shifts it out one
// bit per clock on sout, framed by sframe. A one-cycle done pulse follows the
// final bit of every completed frame. A byte offered during the final bit
// cycle is taken immediately, so back-to-back frames leave no gap.
//
// Optional feature (compile-time macro PARITY_EN): appends one even-parity bit
// (^ of the captured byte) after the 8 data bits, giving a 9-cycle frame.
//
// Parameters:
//   MSB_FIRST   1: din[7] sent first, 0: din[0] sent first
//   IDLE_LEVEL  sout level whenever no frame bit is driven
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   din[7:0]    byte to transmit, sampled on handshake
//   load_valid  upstream offers din
//   load_ready  block can accept din this cycle (registered)
//   sout        serial data (registered)
//   sframe      high while sout carries a frame bit (registered)
//   done        one-cycle pulse after the final frame bit (registered)

module piso_tx8 #(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       load_valid,
    output logic       load_ready,
    output logic       sout,
    output logic       sframe,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t             state, nxt_state;
    logic [DATA_W-1:0]  shreg, nxt_shreg;
    logic [CNT_W-1:0]   bit_cnt, nxt_cnt;
    logic               nxt_sout, nxt_sframe, nxt_done, nxt_ready;
    logic               xfer;
    logic               do_start, do_stop;
`ifdef PARITY_EN
    logic               par_q, nxt_par;
`endif

    // Bit to put on the line next from a byte, in the configured order.
    function automatic logic head_bit(input logic [DATA_W-1:0] b);
        return MSB_FIRST ? b[DATA_W-1] : b[0];
    endfunction

    // Byte with the head bit consumed.
    function automatic logic [DATA_W-1:0] tail_bits(input logic [DATA_W-1:0] b);
        return MSB_FIRST ? {b[DATA_W-2:0], 1'b0} : {1'b0, b[DATA_W-1:1]};
    endfunction

    assign xfer = load_valid & load_ready;

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            shreg      <= 8'h00;
            bit_cnt    <= '0;
            sout       <= IDLE_LEVEL;
            sframe     <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= nxt_state;
            shreg      <= nxt_shreg;
            bit_cnt    <= nxt_cnt;
            sout       <= nxt_sout;
            sframe     <= nxt_sframe;
            done       <= nxt_done;
            load_ready <= nxt_ready;
`ifdef PARITY_EN
            par_q      <= nxt_par;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        nxt_state  = state;
        nxt_shreg  = shreg;
        nxt_cnt    = bit_cnt;
        nxt_sout   = sout;
        nxt_sframe = sframe;
        nxt_done   = 1'b0;
        nxt_ready  = 1'b0;
        do_start   = 1'b0;
        do_stop    = 1'b0;
`ifdef PARITY_EN
        nxt_par    = par_q;
`endif

        case (state)
            S_IDLE: begin
                do_start = xfer;
            end
            S_SHIFT: begin
                if (bit_cnt != LAST_BIT) begin
                    nxt_cnt   = bit_cnt + CNT_W'(1);
                    nxt_sout  = head_bit(shreg);
                    nxt_shreg = tail_bits(shreg);
                end else begin
`ifdef PARITY_EN
                    nxt_state = S_PAR;
                    nxt_sout  = par_q;
`else
                    nxt_done  = 1'b1;
                    do_start  = xfer;
                    do_stop   = !xfer;
`endif
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                nxt_done = 1'b1;
                do_start = xfer;
                do_stop  = !xfer;
            end
`endif
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        // A new frame puts its first bit on the line at this edge.
        if (do_start) begin
            nxt_state  = S_SHIFT;
            nxt_cnt    = '0;
            nxt_sout   = head_bit(din);
            nxt_shreg  = tail_bits(din);
            nxt_sframe = 1'b1;
`ifdef PARITY_EN
            nxt_par    = ^din;
`endif
        end else if (do_stop) begin
            nxt_state  = S_IDLE;
            nxt_cnt    = '0;
            nxt_sout   = IDLE_LEVEL;
            nxt_sframe = 1'b0;
        end

        // Ready while idle or while the final bit of a frame is on the line.
`ifdef PARITY_EN
        nxt_ready = (nxt_state == S_IDLE) || (nxt_state == S_PAR);
`else
        nxt_ready = (nxt_state == S_IDLE) ||
                    ((nxt_state == S_SHIFT) && (nxt_cnt == LAST_BIT));
`endif
    end

endmodule
